// File: rtl/alu_share_arbiter.sv
// Round-robin share of one RV32I ALU among NREQ requesters,
// with a one-entry registered result buffer (valid/ready).
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    per-requester handshake (ready one-hot or 0)
//   req_a/b            32-bit operands, requester i at [32*i +: 32]
//   req_funct3/funct7  op select, same packing
//   rsp_valid/ready    output buffer handshake
//   rsp_result/rsp_id  ALU result and granted requester index
//   grant_cnt          16-bit saturating per-requester grant counters,
//                      present only when ALU_ARB_STATS_EN is defined

module alu_share_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] y
);
  logic       alt;
  logic [4:0] shamt;

  assign alt   = (funct7 == 7'h20);
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    unique case (funct3)
      3'd0: y = alt ? a - b : a + b;
      3'd1: y = a << shamt;
      3'd2: y = {31'b0, $signed(a) < $signed(b)};
      3'd3: y = {31'b0, a < b};
      3'd4: y = a ^ b;
      3'd5: y = alt ? $unsigned($signed(a) >>> shamt)
                    : a >> shamt;
      3'd6: y = a | b;
      3'd7: y = a & b;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_funct3,
  input  logic [NREQ*7-1:0]  req_funct7,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [IDW-1:0]    rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  buf_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] rr_next;
  logic [IDW:0]   cand;
  logic           gnt_found;
  logic           can_accept;
  logic           xfer;
  logic [31:0]    a_g;
  logic [31:0]    b_g;
  logic [2:0]     f3_g;
  logic [6:0]     f7_g;
  logic [31:0]    alu_y;

  assign can_accept = (state == EMPTY) || rsp_ready;

  // Priority search from rr_ptr upward, wrapping at NREQ.
  // Constant indices only, so the compare picks the slot.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W)
        cand = cand - NREQ_W;
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && cand == (IDW+1)'(i)
            && req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    a_g  = '0;
    b_g  = '0;
    f3_g = '0;
    f7_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_g  = req_a[32*i +: 32];
        b_g  = req_b[32*i +: 32];
        f3_g = req_funct3[3*i +: 3];
        f7_g = req_funct7[7*i +: 7];
      end
    end
  end

  assign xfer = !reset && gnt_found && can_accept;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = xfer && (gnt_idx == IDW'(i));
  end

  assign rr_next = (gnt_idx == IDW'(NREQ-1))
                 ? '0 : gnt_idx + IDW'(1);

  alu_share_alu u_alu (
    .a      (a_g),
    .b      (b_g),
    .funct3 (f3_g),
    .funct7 (f7_g),
    .y      (alu_y)
  );

  // Reload on transfer even when draining: 1 result/cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      state      <= FULL;
      rsp_valid  <= 1'b1;
      rsp_result <= alu_y;
      rsp_id     <= gnt_idx;
      rr_ptr     <= rr_next;
    end else if (rsp_ready) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && gnt_idx == IDW'(i)
            && grant_cnt[16*i +: 16] != 16'hFFFF)
          grant_cnt[16*i +: 16] <=
            grant_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
